// File: rtl/irrigation_controller.sv
// Multi-zone irrigation sequencer: tank fill supervision, per-zone sprinkler/drip
// watering with latched round parameters, timed cleaning drain and latched faults.
module irrigation_controller #(
    parameter int ZONES        = 4,
    parameter int DUR_W        = 8,
    parameter int FILL_TIMEOUT = 200,
    parameter int CLEAN_CYCLES = 16
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     H,
    input  logic                                     M,
    input  logic                                     L,
    input  logic                                     E,
    input  logic                                     ack,
    input  logic                                     start,
    input  logic [ZONES-1:0]                         zone_en,
    input  logic [ZONES-1:0]                         zone_mode,
    input  logic [DUR_W-1:0]                         dur_sprk,
    input  logic [DUR_W-1:0]                         dur_drip,
    output logic [ZONES-1:0]                         valve_zone,
    output logic                                     Ag,
    output logic                                     fill_valve,
    output logic                                     drain_valve,
    output logic [2:0]                               state_code,
    output logic [((ZONES > 1) ? $clog2(ZONES) : 1)-1:0] zone_idx,
    output logic [1:0]                               err_code,
    output logic                                     busy,
    output logic                                     round_done
);

    // state    | meaning
    // S_FILL   | tank filling, fill timeout running
    // S_FULL   | tank full, idle, waiting for start
    // S_WATER  | one zone valve open, duration timer running
    // S_CLEAN  | cleaning drain for CLEAN_CYCLES cycles
    // S_ERR    | fault latched in err_q, waiting for ack
    localparam logic [2:0] S_FILL  = 3'd0;
    localparam logic [2:0] S_FULL  = 3'd1;
    localparam logic [2:0] S_WATER = 3'd2;
    localparam logic [2:0] S_CLEAN = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam int ZW   = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int FT_W = $clog2(FILL_TIMEOUT + 1);
    localparam int CL_W = $clog2(CLEAN_CYCLES + 1);
    localparam int TW0  = (FT_W > CL_W) ? FT_W : CL_W;
    localparam int TW   = (TW0 > DUR_W) ? TW0 : DUR_W;

    localparam logic [TW-1:0] FILL_LOAD  = TW'(FILL_TIMEOUT - 1);
    localparam logic [TW-1:0] CLEAN_LOAD = TW'(CLEAN_CYCLES - 1);

    logic [2:0]       state;
    logic [TW-1:0]    timer;
    logic [ZW-1:0]    ptr;
    logic [ZONES-1:0] en_q;
    logic [ZONES-1:0] mode_q;
    logic [DUR_W-1:0] sprk_q;
    logic [DUR_W-1:0] drip_q;
    logic [1:0]       err_q;
    logic             rd_q;

    logic [ZW-1:0]    first_idx;
    logic [ZW-1:0]    next_idx;
    logic             next_found;
    logic [DUR_W-1:0] first_dur;
    logic [DUR_W-1:0] next_dur;
    logic             in_water;

    // Timer counts down to 0, so a zone open for d cycles loads d-1; d=0 behaves as d=1.
    function automatic logic [TW-1:0] dur_load(input logic [DUR_W-1:0] d);
        return (d == '0) ? '0 : (TW'(d) - TW'(1));
    endfunction

    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = ZONES - 1; i >= 0; i--) begin
            if (zone_en[i]) begin
                first_idx = ZW'(i);
            end
        end
        for (int i = ZONES - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(ptr))) begin
                next_idx   = ZW'(i);
                next_found = 1'b1;
            end
        end
        first_dur = zone_mode[first_idx] ? dur_sprk : dur_drip;
        next_dur  = mode_q[next_idx] ? sprk_q : drip_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_FILL;
            timer  <= FILL_LOAD;
            ptr    <= '0;
            en_q   <= '0;
            mode_q <= '0;
            sprk_q <= '0;
            drip_q <= '0;
            err_q  <= 2'd0;
            rd_q   <= 1'b0;
        end else begin
            rd_q <= 1'b0;
            if (E) begin
                state <= S_ERR;
                err_q <= 2'd1;
            end else if (H && L && (state != S_ERR)) begin
                state <= S_ERR;
                err_q <= 2'd3;
            end else begin
                case (state)
                    S_FILL: begin
                        if (H) begin
                            state <= S_FULL;
                        end else if (timer == '0) begin
                            state <= S_ERR;
                            err_q <= 2'd2;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_FULL: begin
                        if (start && (zone_en != '0)) begin
                            en_q   <= zone_en;
                            mode_q <= zone_mode;
                            sprk_q <= dur_sprk;
                            drip_q <= dur_drip;
                            ptr    <= first_idx;
                            timer  <= dur_load(first_dur);
                            state  <= S_WATER;
                        end
                    end
                    S_WATER: begin
                        if (L) begin
                            state <= S_CLEAN;
                            timer <= CLEAN_LOAD;
                        end else if (timer == '0) begin
                            if (next_found) begin
                                ptr   <= next_idx;
                                timer <= dur_load(next_dur);
                            end else begin
                                state <= S_CLEAN;
                                timer <= CLEAN_LOAD;
                                rd_q  <= 1'b1;
                            end
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_CLEAN: begin
                        if (timer == '0) begin
                            state <= S_FILL;
                            timer <= FILL_LOAD;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    S_ERR: begin
                        // E is already known low here; H&L must also be clear to leave.
                        if (ack && !(H && L)) begin
                            state <= S_FILL;
                            timer <= FILL_LOAD;
                            err_q <= 2'd0;
                        end
                    end
                    default: begin
                        state <= S_FILL;
                        timer <= FILL_LOAD;
                    end
                endcase
            end
        end
    end

    assign in_water    = (state == S_WATER);
    assign valve_zone  = in_water ? (ZONES'(1) << ptr) : '0;
    assign Ag          = in_water & mode_q[ptr];
    assign fill_valve  = (state == S_FILL);
    assign drain_valve = (state == S_CLEAN);
    assign state_code  = in_water ? (mode_q[ptr] ? 3'd2 : 3'd3) : state;
    assign zone_idx    = in_water ? ptr : '0;
    assign err_code    = err_q;
    assign busy        = (state != S_FULL);
    assign round_done  = rd_q;

endmodule

// File: tb/tb_irrigation_controller.sv
// Directed bench for irrigation_controller (ZONES=4, FILL_TIMEOUT=8, CLEAN_CYCLES=4)
// with hand-computed per-cycle expectations.
module tb_irrigation_controller;

    logic       clock = 1'b0;
    logic       reset, H, M, L, E, ack, start;
    logic [3:0] zone_en, zone_mode;
    logic [7:0] dur_sprk, dur_drip;
    logic [3:0] valve_zone;
    logic       Ag, fill_valve, drain_valve, busy, round_done;
    logic [2:0] state_code;
    logic [1:0] zone_idx;
    logic [1:0] err_code;

    int total = 0;
    int bad   = 0;

    irrigation_controller #(
        .ZONES(4), .DUR_W(8), .FILL_TIMEOUT(8), .CLEAN_CYCLES(4)
    ) dut (
        .clock(clock), .reset(reset), .H(H), .M(M), .L(L), .E(E), .ack(ack),
        .start(start), .zone_en(zone_en), .zone_mode(zone_mode),
        .dur_sprk(dur_sprk), .dur_drip(dur_drip), .valve_zone(valve_zone),
        .Ag(Ag), .fill_valve(fill_valve), .drain_valve(drain_valve),
        .state_code(state_code), .zone_idx(zone_idx), .err_code(err_code),
        .busy(busy), .round_done(round_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] sc, input logic [3:0] vz,
                           input logic ag, input logic fv, input logic dv,
                           input logic [1:0] zi, input logic [1:0] ec, input logic rd);
        chk({tag, ".state_code"}, 32'(state_code), 32'(sc));
        chk({tag, ".valve_zone"}, 32'(valve_zone), 32'(vz));
        chk({tag, ".Ag"}, 32'(Ag), 32'(ag));
        chk({tag, ".fill_valve"}, 32'(fill_valve), 32'(fv));
        chk({tag, ".drain_valve"}, 32'(drain_valve), 32'(dv));
        chk({tag, ".zone_idx"}, 32'(zone_idx), 32'(zi));
        chk({tag, ".err_code"}, 32'(err_code), 32'(ec));
        chk({tag, ".busy"}, 32'(busy), 32'(sc != 3'd1));
        chk({tag, ".round_done"}, 32'(round_done), 32'(rd));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_round(input logic [3:0] en, input logic [3:0] md,
                             input logic [7:0] ds, input logic [7:0] dd);
        zone_en = en; zone_mode = md; dur_sprk = ds; dur_drip = dd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; H = 1'b1; M = 1'b0; L = 1'b0; E = 1'b0; ack = 1'b0; start = 1'b0;
        set_round(4'b0000, 4'b0000, 8'd0, 8'd0);

        // reset with tank full
        tick();
        chk_out("rst", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);
        reset = 1'b0;
        tick();
        chk_out("full", 3'd1, 4'b0000, 0, 0, 0, 2'd0, 2'd0, 0);

        // two-zone round; inputs scrambled after start to prove latching
        set_round(4'b1010, 4'b0010, 8'd3, 8'd5);
        start = 1'b1;
        tick();
        start = 1'b0; M = 1'b1;
        set_round(4'b0101, 4'b1111, 8'd1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            chk_out("z1", 3'd2, 4'b0010, 1, 0, 0, 2'd1, 2'd0, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            chk_out("z3", 3'd3, 4'b1000, 0, 0, 0, 2'd3, 2'd0, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk_out("clean", 3'd4, 4'b0000, 0, 0, 1, 2'd0, 2'd0, (i == 0));
            tick();
        end
        chk_out("refill", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);
        M = 1'b0;
        tick();
        chk("back_full", 32'(state_code), 32'd1);

        // zero drip duration opens the zone for exactly one cycle
        set_round(4'b0001, 4'b0000, 8'd7, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("dur0", 3'd3, 4'b0001, 0, 0, 0, 2'd0, 2'd0, 0);
        tick();
        chk_out("dur0_end", 3'd4, 4'b0000, 0, 0, 1, 2'd0, 2'd0, 1);
        repeat (5) tick();
        chk("dur0_full", 32'(state_code), 32'd1);

        // start with no zones enabled is ignored
        set_round(4'b0000, 4'b1111, 8'd3, 8'd3);
        start = 1'b1;
        tick();
        chk("nozone_a", 32'(state_code), 32'd1);
        tick();
        start = 1'b0;
        chk("nozone_b", 32'(state_code), 32'd1);

        // external fault in the second zone
        set_round(4'b1010, 4'b0010, 8'd3, 8'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk_out("e_z3", 3'd3, 4'b1000, 0, 0, 0, 2'd3, 2'd0, 0);
        E = 1'b1;
        tick();
        chk_out("e_err", 3'd5, 4'b0000, 0, 0, 0, 2'd0, 2'd1, 0);
        ack = 1'b1;
        tick();
        chk_out("e_ackE", 3'd5, 4'b0000, 0, 0, 0, 2'd0, 2'd1, 0);
        ack = 1'b0; E = 1'b0;
        tick();
        chk_out("e_hold", 3'd5, 4'b0000, 0, 0, 0, 2'd0, 2'd1, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_out("e_exit", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);
        tick();
        chk("e_full", 32'(state_code), 32'd1);

        // low-level abort during the first of three zones
        set_round(4'b0111, 4'b0000, 8'd2, 8'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("l_z0", 3'd3, 4'b0001, 0, 0, 0, 2'd0, 2'd0, 0);
        H = 1'b0; L = 1'b1;
        tick();
        L = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_out("l_clean", 3'd4, 4'b0000, 0, 0, 1, 2'd0, 2'd0, 0);
            tick();
        end
        H = 1'b1;
        chk_out("l_fill", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);
        tick();
        chk("l_full", 32'(state_code), 32'd1);

        // level inconsistency in FULL_BOX
        L = 1'b1;
        tick();
        chk_out("hl_err", 3'd5, 4'b0000, 0, 0, 0, 2'd0, 2'd3, 0);
        ack = 1'b1;
        tick();
        chk("hl_stuck", 32'(state_code), 32'd5);
        L = 1'b0;
        tick();
        ack = 1'b0;
        chk_out("hl_exit", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);
        tick();
        chk("hl_full", 32'(state_code), 32'd1);

        // reset mid-round
        set_round(4'b1010, 4'b0010, 8'd3, 8'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mr_water", 32'(state_code), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_out("mr_rst", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);
        tick();
        chk("mr_full", 32'(state_code), 32'd1);

        // fill timeout with tank never full
        H = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_out("fill_to", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);
            tick();
        end
        chk_out("to_err", 3'd5, 4'b0000, 0, 0, 0, 2'd0, 2'd2, 0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk_out("to_exit", 3'd0, 4'b0000, 0, 1, 0, 2'd0, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irrigation_controller.md
# irrigation_controller

Parametrised multi-zone irrigation controller: the successor of the single-tank sprinkler/drip state machine. It drives up to ZONES valves in sequence, with a per-zone sprinkler/drip mode and a programmable watering duration. It supervises tank filling with a timeout, runs a timed cleaning drain and latches classified faults until acknowledged. It sits between the sensor/keypad inputs and the display/LED-matrix drivers, which decode `state_code`, `zone_idx` and `err_code`.

## Interface
- ZONES, 4: number of irrigation zones (1..16)
- DUR_W, 8: width of duration operands
- FILL_TIMEOUT, 200: max cycles in FILLING before fault
- CLEAN_CYCLES, 16: drain duration in cycles (≥1)

Ports:
- clock  in  1  system clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high
- H, M, L  in  1  tank level: H = full, M = mid (status only), L = below low mark
- E  in  1  external fault, level-sensitive
- ack  in  1  fault acknowledge
- start  in  1  request a watering round
- zone_en  in  ZONES  zones enabled for the round
- zone_mode  in  ZONES  per zone: 1 = sprinkler, 0 = drip
- dur_sprk, dur_drip  in  DUR_W  per-zone watering cycles, by mode
- valve_zone  out  ZONES  one-hot active zone valve, or 0
- Ag  out  1  sprinkler pump; 1 iff the active zone is sprinkler
- fill_valve, drain_valve  out  1  tank fill and cleaning drain
- state_code  out  3  0 FILLING, 1 FULL_BOX, 2 WATER-sprinkler, 3 WATER-drip, 4 CLEANING, 5 ERROR
- zone_idx  out  max(1,clog2(ZONES))  active zone index; 0 outside WATER
- err_code  out  2  0 none, 1 external E, 2 fill timeout, 3 level inconsistency (H&L)
- busy  out  1  1 in every state except FULL_BOX
- round_done  out  1  one-cycle pulse on normal round completion

## Operation
- All outputs decode from registered state, zone pointer and err register. No input reaches an output combinationally.
- Transition priority, highest first:
  - reset
  - E=1 → ERROR, err 1
  - H&L=1 (outside ERROR) → ERROR, err 3
  - state-specific rules below
- FILLING:
  - fill_valve=1; cycle counter starts at 0 on entry.
  - H=1 → FULL_BOX.
  - Counter reaching FILL_TIMEOUT−1 with H=0 → ERROR, err 2.
- FULL_BOX:
  - Idle, all valves 0.
  - start=1 with zone_en≠0 → latch zone_en, zone_mode, dur_sprk, dur_drip; enter WATER at the lowest enabled zone.
  - start with zone_en=0 is ignored.
  - Inputs that change after latching do not affect the running round.
- WATER:
  - valve_zone = one-hot(pointer); Ag = latched mode bit.
  - Duration timer loads from the mode-selected latched duration; a duration of 0 is treated as 1.
  - Zone stays active exactly dur cycles, then the pointer advances to the next higher enabled zone with no gap cycle.
  - After the last enabled zone → CLEANING with round_done=1 for the first CLEANING cycle.
  - L=1 → abort: CLEANING next cycle, round_done stays 0, remaining zones skipped.
- CLEANING: drain_valve=1 for exactly CLEAN_CYCLES cycles, then FILLING.
- ERROR:
  - All valves, Ag and round_done are 0; err_code holds.
  - Exit to FILLING only when ack=1, E=0 and !(H&L) in the same cycle. err_code clears to 0 on exit.
  - ack in any other state is ignored.
- M has no effect on transitions.

## Timing
- Reset values:
  - state FILLING (state_code 0), fill_valve 1
  - valve_zone 0, Ag 0, drain_valve 0
  - zone_idx 0, err_code 0, busy 1, round_done 0
- An input sampled at edge k changes outputs after edge k (visible in cycle k+1). All transitions have 1-cycle latency.
- start sampled at edge k → first zone active cycles k+1 … k+dur.
- Timers reload on every state entry; no stale counts survive ERROR or reset.
- reset mid-round aborts immediately, with no round_done.
- E asserted in the same cycle as zone completion or round completion → ERROR wins; no round_done.

## Test plan
- Reset with H=1: cycle 1 shows state_code 0, fill_valve 1; cycle 2 shows state_code 1, fill_valve 0, busy 0.
- ZONES=4, CLEAN_CYCLES=4, zone_en=1010, zone_mode=0010, dur_sprk=3, dur_drip=5, start pulse:
  - valve_zone 0010, Ag 1, state_code 2, zone_idx 1 for 3 cycles
  - then 1000, Ag 0, state_code 3, zone_idx 3 for 5 cycles
  - then drain_valve 1 for 4 cycles with round_done on the first of them, then FILLING
- FILL_TIMEOUT=8, H held 0: fill_valve 1 for 8 cycles, then ERROR with err_code 2. ack=1 with E=0 → FILLING next cycle, err_code 0.
- E pulse during the second zone: next cycle state_code 5, err_code 1, all valves 0. ack while E=1 keeps ERROR; ack after E=0 → FILLING.
- L=1 during the first zone of a 3-zone round: CLEANING next cycle, round_done never asserted, later zones never opened.
- Edge cases:
  - start with zone_en=0000 in FULL_BOX: state stays 1.
  - H=L=1 in FULL_BOX: ERROR with err_code 3.
  - dur_drip=0: zone open exactly 1 cycle.
